// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, immediate-format enum and the
// per-entry decoded field bundle stored in the instruction buffer.
package decode_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   // IMM_R is encoded as zero so an idle output bus reads all zeros.
   typedef enum logic [2:0] {
      IMM_R    = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5,
      IMM_NONE = 3'd6
   } imm_type_e;

   // Width-independent part of a decoded entry; imm and pc are kept alongside
   // it in the buffer because their width follows XLEN.
   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [6:0] funct7;
      imm_type_e  imm_type;
      logic       illegal;
   } dec_entry_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction and format classification for one 32-bit instruction.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output imm_type_e       imm_type
);

   logic [31:0] imm32;

   // Pick the immediate layout from the opcode; unknown opcodes give zero/NONE.
   always_comb begin
      imm32    = '0;
      imm_type = IMM_NONE;
      case (instr[6:0])
         OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: begin
            imm32    = {{20{instr[31]}}, instr[31:20]};
            imm_type = IMM_I;
         end
         OP_STORE: begin
            imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            imm_type = IMM_S;
         end
         OP_BRANCH: begin
            imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            imm_type = IMM_B;
         end
         OP_LUI, OP_AUIPC: begin
            imm32    = {instr[31:12], 12'b0};
            imm_type = IMM_U;
         end
         OP_JAL: begin
            imm32    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            imm_type = IMM_J;
         end
         OP_OP: begin
            imm_type = IMM_R;
         end
         default: ;
      endcase
   end

   // Every format is sign-extended from instr[31], so widening imm32 is enough.
   if (XLEN > 32) begin : g_ext
      assign imm = {{(XLEN-32){imm32[31]}}, imm32};
   end else begin : g_noext
      assign imm = imm32;
   end

endmodule

// File: rtl/id_stage.sv
// Decode stage: decodes at the input, buffers decoded entries in a small
// circular queue and presents the head to execute.
module id_stage
   import decode_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int QDEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      opcode,
   output logic [4:0]      rd,
   output logic [2:0]      funct3,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [6:0]      funct7,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      imm_type,
   output logic            illegal
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      dec_entry_t      dec;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
   } slot_t;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   slot_t         slot_q [QDEPTH];
   slot_t         slot_d [QDEPTH];

   logic            push, pop;
   logic [XLEN-1:0] in_imm;
   imm_type_e       in_imm_type;
   slot_t           in_slot;
   slot_t           head;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr    (in_instr),
      .imm      (in_imm),
      .imm_type (in_imm_type)
   );

   // Split fields and flag illegal encodings; illegal entries still flow through.
   always_comb begin
      in_slot              = '0;
      in_slot.dec.opcode   = in_instr[6:0];
      in_slot.dec.rd       = in_instr[11:7];
      in_slot.dec.funct3   = in_instr[14:12];
      in_slot.dec.rs1      = in_instr[19:15];
      in_slot.dec.rs2      = in_instr[24:20];
      in_slot.dec.funct7   = in_instr[31:25];
      in_slot.dec.imm_type = in_imm_type;
      in_slot.dec.illegal  = (in_instr[1:0] != 2'b11) || (in_imm_type == IMM_NONE) ||
                             ((in_imm_type == IMM_R) && (in_instr[31:25] != 7'b0000000) &&
                              (in_instr[31:25] != 7'b0100000) && (in_instr[31:25] != 7'b0000001));
      in_slot.imm          = in_imm;
      in_slot.pc           = in_pc;
   end

   // No pass-through when full: readiness depends only on stored count and flush.
   assign in_ready  = (count_q < CW'(QDEPTH)) && !flush;
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Pointer/count update; flush empties the queue (a concurrent pop is subsumed).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (!push && pop) count_d = count_q - CW'(1);
      end
   end

   // Write the incoming decoded entry into the tail slot.
   always_comb begin
      slot_d = slot_q;
      if (push) slot_d[wr_ptr_q] = in_slot;
   end

   // Control state register; reset wins over flush and handshakes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: it is only visible while out_valid is high.
   always_ff @(posedge clk) begin
      slot_q <= slot_d;
   end

   // Present the head entry, forcing the bus to zero when nothing is valid.
   always_comb begin
      head = '0;
      if (out_valid) head = slot_q[rd_ptr_q];
      out_pc   = head.pc;
      opcode   = head.dec.opcode;
      rd       = head.dec.rd;
      funct3   = head.dec.funct3;
      rs1      = head.dec.rs1;
      rs2      = head.dec.rs2;
      funct7   = head.dec.funct7;
      imm      = head.imm;
      imm_type = head.dec.imm_type;
      illegal  = head.dec.illegal;
   end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc32 = '0;
   logic [63:0] in_pc64 = '0;

   logic        in_ready, out_valid;
   logic [31:0] out_pc, imm;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3, imm_type;
   logic        illegal;

   logic        in_ready64, out_valid64;
   logic [63:0] out_pc64, imm64;
   logic [6:0]  opcode64, funct7_64;
   logic [4:0]  rd64, rs1_64, rs2_64;
   logic [2:0]  funct3_64, imm_type64;
   logic        illegal64;

   always #5 clk = ~clk;

   id_stage #(.XLEN(32), .QDEPTH(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc32), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
      .funct7(funct7), .imm(imm), .imm_type(imm_type), .illegal(illegal)
   );

   id_stage #(.XLEN(64), .QDEPTH(2)) dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_pc(in_pc64), .flush(flush),
      .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
      .opcode(opcode64), .rd(rd64), .funct3(funct3_64), .rs1(rs1_64), .rs2(rs2_64),
      .funct7(funct7_64), .imm(imm64), .imm_type(imm_type64), .illegal(illegal64)
   );

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  f7;
      logic [63:0] imm;
      logic [2:0]  ty;
      logic        ill;
      logic [63:0] pc;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic [63:0] pc_ctr = 64'h8000_0000_0000_1000;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc);
      exp_t e;
      e.op  = i[6:0];
      e.rd  = i[11:7];
      e.f3  = i[14:12];
      e.rs1 = i[19:15];
      e.rs2 = i[24:20];
      e.f7  = i[31:25];
      e.pc  = pc;
      e.imm = '0;
      e.ill = 1'b0;
      case (i[6:0])
         7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin
            e.ty = 3'd1; e.imm = {{52{i[31]}}, i[31:20]};
         end
         7'h23: begin e.ty = 3'd2; e.imm = {{52{i[31]}}, i[31:25], i[11:7]}; end
         7'h63: begin e.ty = 3'd3; e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
         7'h37, 7'h17: begin e.ty = 3'd4; e.imm = {{32{i[31]}}, i[31:12], 12'h000}; end
         7'h6F: begin e.ty = 3'd5; e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
         7'h33: begin
            e.ty  = 3'd0;
            e.ill = !(i[31:25] == 7'h00 || i[31:25] == 7'h20 || i[31:25] == 7'h01);
         end
         default: begin e.ty = 3'd6; e.ill = 1'b1; end
      endcase
      if (i[1:0] != 2'b11) e.ill = 1'b1;
      return e;
   endfunction

   // One cycle: drive at negedge, check 1 ns later, update scoreboard for the coming edge.
   task automatic step(input logic v, input logic [31:0] ins, input logic r, input logic f);
      logic exp_rdy;
      exp_t e;
      @(negedge clk);
      in_valid  = v;
      in_instr  = ins;
      in_pc64   = pc_ctr;
      in_pc32   = pc_ctr[31:0];
      out_ready = r;
      flush     = f;
      #1;
      exp_rdy = (sb.size() < 2) && !f;
      chk("in_ready", in_ready, exp_rdy);
      chk("in_ready64", in_ready64, exp_rdy);
      if (sb.size() == 0) begin
         chk("out_valid_idle", out_valid, 0);
         chk("out_valid64_idle", out_valid64, 0);
         chk("idle_fields", {opcode, rd, funct3, rs1, rs2, funct7, imm_type, illegal}, 0);
         chk("idle_imm", imm, 0);
         chk("idle_pc", out_pc, 0);
         chk("idle_imm64", imm64, 0);
         chk("idle_pc64", out_pc64, 0);
      end else begin
         e = sb[0];
         chk("out_valid", out_valid, 1);
         chk("out_valid64", out_valid64, 1);
         chk("opcode", opcode, e.op);
         chk("rd", rd, e.rd);
         chk("funct3", funct3, e.f3);
         chk("rs1", rs1, e.rs1);
         chk("rs2", rs2, e.rs2);
         chk("funct7", funct7, e.f7);
         chk("imm", imm, e.imm[31:0]);
         chk("imm_type", imm_type, e.ty);
         chk("illegal", illegal, e.ill);
         chk("out_pc", out_pc, e.pc[31:0]);
         chk("imm64", imm64, e.imm);
         chk("out_pc64", out_pc64, e.pc);
         chk("illegal64", illegal64, e.ill);
      end
      if (sb.size() != 0 && r) void'(sb.pop_front());
      if (f) sb.delete();
      else if (v && exp_rdy) begin
         sb.push_back(model(ins, pc_ctr));
         pc_ctr = pc_ctr + 64'd4;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst       = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h0010_0093;
      out_ready = 1'b0;
      flush     = 1'b0;
      repeat (n) @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      sb.delete();
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_valid64", out_valid64, 0);
      chk("rst_fields", {opcode, rd, imm, out_pc, imm_type, illegal}, 0);
   endtask

   logic [31:0] d_ins [8];
   logic [63:0] d_imm [8];
   logic [2:0]  d_ty  [8];
   logic        d_ill [8];
   logic [4:0]  d_rd  [8];
   logic [6:0]  pool  [11];

   initial begin
      d_ins = '{32'hFFF1_0093, 32'h0051_2423, 32'hFE00_0EE3, 32'h1234_51B7,
                32'h0010_00EF, 32'h0000_0000, 32'h0020_81B3, 32'h0420_81B3};
      d_imm = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1234_5000,
                64'h800, 64'h0, 64'h0, 64'h0};
      d_ty  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0};
      d_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      d_rd  = '{5'd1, 5'd8, 5'd29, 5'd3, 5'd1, 5'd0, 5'd3, 5'd3};
      pool  = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

      do_reset(2);

      // Directed decode vectors against hand-computed constants.
      for (int k = 0; k < 8; k++) begin
         step(1'b1, d_ins[k], 1'b1, 1'b0);
         step(1'b0, 32'h0, 1'b1, 1'b0);
         chk("dir_imm", imm, d_imm[k][31:0]);
         chk("dir_imm64", imm64, d_imm[k]);
         chk("dir_type", imm_type, d_ty[k]);
         chk("dir_illegal", illegal, d_ill[k]);
         chk("dir_rd", rd, d_rd[k]);
         if (k == 0) begin
            chk("addi_opcode", opcode, 7'h13);
            chk("addi_rs1", rs1, 5'd2);
         end
      end
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Backpressure: two accepted, third held off until a slot frees up.
      step(1'b1, 32'h0010_0093, 1'b0, 1'b0);
      step(1'b1, 32'h0020_0113, 1'b0, 1'b0);
      step(1'b1, 32'h0030_0193, 1'b0, 1'b0);
      chk("full_in_ready", in_ready, 0);
      step(1'b1, 32'h0030_0193, 1'b1, 1'b0);
      chk("full_pop_no_bypass", in_ready, 0);
      step(1'b1, 32'h0030_0193, 1'b1, 1'b0);
      chk("third_accepted", in_ready, 1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Flush with two buffered and one incoming.
      step(1'b1, 32'h0051_2423, 1'b0, 1'b0);
      step(1'b1, 32'hFE00_0EE3, 1'b0, 1'b0);
      step(1'b1, 32'h1234_51B7, 1'b0, 1'b1);
      chk("flush_in_ready", in_ready, 0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("flush_out_valid", out_valid, 0);

      // Reset in the middle of operation with one entry buffered.
      step(1'b1, 32'h0010_00EF, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("pre_rst_valid", out_valid, 1);
      do_reset(1);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Random traffic with occasional flushes.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] r, ins;
         r   = $urandom();
         ins = {r[31:7], pool[$urandom_range(0, 10)]};
         if ($urandom_range(0, 9) == 0) ins = $urandom();
         if ($urandom_range(0, 3) == 0) ins[31:25] = 7'h00;
         step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0,
              $urandom_range(0, 24) == 0);
      end
      for (int n = 0; n < 4; n++) step(1'b0, 32'h0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and immediate width (32 or 64).
REQ-002 SHALL have parameter QDEPTH, default 2, decoded-entry buffer depth (power of two, >=2).
REQ-003 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have in_valid  input  1, in_ready  output  1, in_instr  input  32, in_pc  input  XLEN: fetch-side handshake.
REQ-006 SHALL have flush  input  1  discard all buffered and incoming instructions.
REQ-007 SHALL have out_valid  output  1, out_ready  input  1, out_pc  output  XLEN: execute-side handshake.
REQ-008 SHALL have opcode 7, rd 5, funct3 3, rs1 5, rs2 5, funct7 7, imm XLEN, imm_type 3, illegal 1, all outputs: decoded fields of the head entry.

Function
REQ-009 SHALL accept an instruction on a cycle where in_valid && in_ready, and pop the head on a cycle where out_valid && out_ready.
REQ-010 SHALL drive in_ready = (count < QDEPTH) && !flush, with no full-state pass-through.
REQ-011 SHALL present an accepted instruction on out_valid no earlier than the following cycle: latency 1, throughput 1 per cycle.
REQ-012 SHALL decode fields combinationally at input: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25], and store them with in_pc.
REQ-013 SHALL generate imm as sign-extended to XLEN from instr[31]:
- I (0000011, 0010011, 1100111, 0001111, 1110011): instr[31:20].
- S (0100011): {instr[31:25], instr[11:7]}.
- B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U (0110111, 0010111): {instr[31:12], 12'b0}.
- J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- R (0110011) and all others: 0.
REQ-014 SHALL set imm_type to IMM_R/I/S/B/U/J/NONE per REQ-013; NONE for unrecognised opcodes.
REQ-015 SHALL set illegal when any of the following holds, and still buffer and emit the entry:
- instr[1:0] != 2'b11;
- opcode is not listed in REQ-013;
- R-type funct7 is not 0000000, 0100000 or 0000001.
REQ-016 SHALL keep count unchanged on a simultaneous push and pop, and wrap read/write pointers modulo QDEPTH.
REQ-017 SHALL hold all out_* fields stable while out_valid && !out_ready.
REQ-018 SHALL drive all decoded outputs and out_pc to 0 whenever out_valid=0.
REQ-019 SHALL, on a flush cycle, accept nothing, zero count and pointers, and show out_valid=0 on the next cycle; a pop in the flush cycle is still honoured.

Reset
REQ-020 SHALL, when rst=0 at a clk edge, clear count, pointers and out_valid to 0; all outputs read 0 and in_ready=1 on the first cycle after release.
REQ-021 SHALL discard buffered contents on reset asserted mid-operation; reset has priority over flush and handshakes.

Structure
REQ-022 SHALL take opcode constants, the imm_type enum and a decoded-entry struct from shared package decode_pkg.
REQ-023 SHALL implement immediate generation in a combinational sub-module imm_gen (instr, XLEN -> imm, imm_type); the buffer stays inline.

Verification
REQ-024 SHALL check each of the following directed scenarios:
- addi 0xFFF10093 -> opcode 0x13, rd 1, rs1 2, imm 0xFFFFFFFF, imm_type I, illegal 0.
- sw 0x00512423 -> imm 0x8, type S; beq 0xFE000EE3 -> imm 0xFFFFFFFC, type B.
- lui 0x123451B7 -> imm 0x12345000, type U; jal 0x001000EF -> rd 1, imm 0x00000800, type J; XLEN=64 gives upper bits sign-extended.
- QDEPTH=2, out_ready=0, push 3 instrs -> in_ready 0 after 2 accepts; release out_ready -> order preserved, third accepted.
- Buffer with 2 entries, flush=1 with in_valid=1 -> out_valid 0 next cycle, incoming dropped; instr 0x00000000 -> illegal 1, imm_type NONE.
- rst=0 mid-stream with 1 entry -> out_valid 0, in_ready 1 after release.
